// File: rtl/xor_parity_rx.sv
// Serial start/data/parity/stop frame receiver with XOR parity and framing checks.
// Completed frames are handed to the consumer through a one-entry valid/ready register.
module xor_parity_rx #(
    parameter int unsigned DATA_W     = 8,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              rx,
    output logic [DATA_W-1:0] out_data,
    output logic              out_perr,
    output logic              out_ferr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                acc_q, acc_d;
    logic                perr_q, perr_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_perr_q, out_perr_d;
    logic                out_ferr_q, out_ferr_d;
    logic                out_valid_q, out_valid_d;
    logic                overrun_q, overrun_d;
    logic                frame_done;
    logic                ferr_new;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        perr_d      = perr_q;
        out_data_d  = out_data_q;
        out_perr_d  = out_perr_q;
        out_ferr_d  = out_ferr_q;
        out_valid_d = out_valid_q;
        overrun_d   = 1'b0;
        frame_done  = 1'b0;
        ferr_new    = 1'b0;

        if (bit_en) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        acc_d   = 1'b0;
                    end
                end
                S_DATA: begin
                    // LSB arrives first, so new bits enter at the top and walk down
                    shift_d             = shift_q >> 1;
                    shift_d[DATA_W-1]   = rx;
                    acc_d               = acc_q ^ rx;
                    cnt_d               = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    perr_d  = acc_q ^ rx ^ PARITY_ODD;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    frame_done = 1'b1;
                    ferr_new   = ~rx;
                    state_d    = rx ? S_IDLE : S_BREAK;
                end
                S_BREAK: begin
                    if (rx) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (frame_done) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = shift_q;
                out_perr_d  = perr_q;
                out_ferr_d  = ferr_new;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            acc_q       <= 1'b0;
            perr_q      <= 1'b0;
            out_data_q  <= '0;
            out_perr_q  <= 1'b0;
            out_ferr_q  <= 1'b0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            perr_q      <= perr_d;
            out_data_q  <= out_data_d;
            out_perr_q  <= out_perr_d;
            out_ferr_q  <= out_ferr_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_perr  = out_perr_q;
    assign out_ferr  = out_ferr_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/xor_parity_rx.md
# xor_parity_rx

Serial frame receiver with XOR parity check: the receive-side counterpart to the team's XOR parity generators. It deserializes start/data/parity/stop frames from a single line, recomputes parity with an XOR reduction, and flags parity and framing errors. Each frame is delivered through a one-entry valid/ready output register. It sits between the line interface (which supplies a mid-bit sample strobe) and the byte consumer.

## Interface
- DATA_W, 8: data bits per frame, LSB first; legal range 1..16.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity.

- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- bit_en  input  1  one-cycle strobe per bit period, aligned mid-bit; rx is sampled only when bit_en=1.
- rx  input  1  serial line, idles high.
- out_data  output  DATA_W  received data word.
- out_perr  output  1  parity error for the frame in out_data.
- out_ferr  output  1  framing error (stop bit sampled 0) for the frame in out_data.
- out_valid  output  1  out_data/out_perr/out_ferr are valid.
- out_ready  input  1  consumer accepts when out_valid && out_ready.
- overrun  output  1  one-cycle pulse: a completed frame was dropped.
- busy  output  1  high in any state other than IDLE.

## Operation
- States: IDLE, DATA, PARITY, STOP, BREAK. Transitions occur only on cycles with bit_en=1.
- IDLE:
  - If rx=0, go to DATA. Clear the bit counter and the parity accumulator (acc).
  - If rx=1, stay in IDLE.
- DATA: shift rx into the shift register LSB first and update acc ^= rx. After DATA_W bits, go to PARITY.
- PARITY: perr = acc ^ rx ^ PARITY_ODD. Even mode: total count of ones across data and parity bit must be even, otherwise perr=1. Go to STOP.
- STOP: ferr = ~rx. The frame is complete on this cycle.
  - If rx=1, go to IDLE.
  - If rx=0, go to BREAK.
- BREAK: stay until a bit_en with rx=1, then go to IDLE. No start bit is detected while in BREAK.
- Output register, evaluated on the frame-complete cycle:
  - If register empty (out_valid=0): load data/perr/ferr and set out_valid=1.
  - If register full and out_valid && out_ready in the same cycle: load the new frame and keep out_valid=1. No overrun.
  - If register full and out_ready=0: drop the new frame, keep old contents, and pulse overrun for 1 cycle.
- Acceptance without a new frame completing clears out_valid. out_data, out_perr and out_ferr hold their last values.
- A frame with perr or ferr is still delivered; the flags describe that frame only.
- Parity and framing errors are never sticky.

## Timing
- Reset values: state=IDLE, out_data=0, out_perr=0, out_ferr=0, out_valid=0, overrun=0, busy=0. The shift register, counter and acc are also 0.
- Assertion of rst_n low mid-frame discards the partial frame immediately, with no output.
- Latency: out_valid rises on the clk edge after the stop-bit bit_en cycle, i.e. registered output with 1-cycle latency.
- busy rises the cycle after start-bit detection and falls the cycle after the STOP or BREAK exit.
- A frame is 1 + DATA_W + 2 bit_en strobes. The next start bit may be sampled on the very next bit_en after STOP.
- bit_en spacing is arbitrary; back-to-back strobes on consecutive clocks must work.
- out_ready is combinationally unused for rx path. Accept takes effect on the same edge.

## Test plan
- Even parity, frame 0xA5 with parity bit 0 and stop 1, out_ready=1: expect out_data=0xA5, out_perr=0, out_ferr=0, and out_valid high for 1 cycle.
- Same frame with parity bit 1: expect out_data=0xA5, out_perr=1. Repeat with PARITY_ODD=1 and parity bit 1: expect out_perr=0.
- Frame 0x3C with stop bit 0, then rx held low for 3 bit_en strobes, then high: expect out_ferr=1. No new frame may start until rx=1 is sampled; the next 0x11 frame is received correctly.
- out_ready=0, send 0x01 then 0x02: expect out_data stays 0x01, one overrun pulse, out_valid=1. With out_ready=1 on the 0x03 completion cycle: expect 0x03 loaded and no overrun.
- Reset mid-frame after 4 data bits: expect all outputs at reset values. A following complete 0x5A frame is received cleanly.
- bit_en every clock, 4 back-to-back frames 0x00, 0xFF, 0x80, 0x7F with out_ready=1: expect all four delivered in order with correct parity flags.
